ecat_rx_frame_packer: RTL and testbench

//  Packs the EtherCAT MAC RX byte stream into 36-bit words and writes them into
//  the dual-port frame RAM through its write port (data_a/wren_a/address_a).

---
 rtl/ecat_rx_frame_packer.sv | 214 +++++++++++++++++++++
 tb/tb_ecat_rx_frame_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecat_rx_frame_packer.sv
// EtherCAT RX byte stream packer: 36-bit words into frame RAM port A,
// per-frame length header, commit pointer, rewind-on-drop.
module ecat_rx_frame_packer #(
   parameter int ADDR_WIDTH = 9,
   parameter int MAX_BYTES  = 1522
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_sop,
   input  logic                  rx_eop,
   input  logic                  rx_err,
   output logic                  rx_ready,
   input  logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [35:0]           data_a,
   output logic                  wren_a,
   output logic [ADDR_WIDTH-1:0] address_a,
   output logic [ADDR_WIDTH:0]   commit_ptr,
   output logic                  frame_done,
   output logic                  frame_drop,
   output logic [15:0]           ok_cnt,
   output logic [15:0]           drop_cnt
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {IDLE, DATA, LAST, HDR, DROP} state_t;

   state_t         state_q, state_n;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_n;
   logic [PW-1:0]  commit_q, commit_n;
   logic [PW-1:0]  hdr_addr_q, hdr_addr_n;
   logic [31:0]    sr_q, sr_n;
   logic [1:0]     lane_q, lane_n;
   logic [15:0]    cnt_q, cnt_n;
   logic           sopw_q, sopw_n;
   logic           pend_q, pend_n;
   logic [35:0]    pword_q, pword_n;
   logic [15:0]    ok_q, drop_q;
   logic           run_q;

   logic [PW-1:0]  free, free_c, base, fbase;
   logic [31:0]    word_ins;
   logic           acc, start, too_long;

   assign free     = DEPTH - (wr_ptr_q - rd_ptr);
   assign free_c   = DEPTH - (commit_q - rd_ptr);
   assign rx_ready = run_q &&
                     (state_q == IDLE || state_q == DATA || state_q == DROP);
   assign acc      = rx_valid & rx_ready;
   assign too_long = ({1'b0, cnt_q} + 17'd1) > 17'(MAX_BYTES);

   always_comb begin
      word_ins = sr_q;
      word_ins[8*lane_q +: 8] = rx_data;
   end

   always_comb begin
      state_n    = state_q;
      wr_ptr_n   = wr_ptr_q;
      commit_n   = commit_q;
      hdr_addr_n = hdr_addr_q;
      sr_n       = sr_q;
      lane_n     = lane_q;
      cnt_n      = cnt_q;
      sopw_n     = sopw_q;
      pend_n     = 1'b0;
      pword_n    = pword_q;
      wren_a     = 1'b0;
      address_a  = wr_ptr_q[ADDR_WIDTH-1:0];
      data_a     = pword_q;
      frame_done = 1'b0;
      frame_drop = 1'b0;
      start      = 1'b0;
      base       = wr_ptr_q;
      fbase      = free;

      unique case (state_q)
         IDLE: begin
            if (acc && rx_sop) start = 1'b1;
         end
         DATA: begin
            if (acc && rx_sop) begin
               // Missing eop: abandon the old frame, restart from commit point
               frame_drop = 1'b1;
               wr_ptr_n   = commit_q;
               start      = 1'b1;
               base       = commit_q;
               fbase      = free_c;
            end else if (pend_q && free == '0) begin
               frame_drop = 1'b1;
               wr_ptr_n   = commit_q;
               state_n    = (acc && rx_eop) ? IDLE : DROP;
            end else begin
               if (pend_q) begin
                  wren_a   = 1'b1;
                  wr_ptr_n = wr_ptr_q + PW'(1);
               end
               if (acc) begin
                  if (too_long || (rx_eop && rx_err)) begin
                     wren_a     = 1'b0;
                     frame_drop = 1'b1;
                     wr_ptr_n   = commit_q;
                     state_n    = rx_eop ? IDLE : DROP;
                  end else begin
                     cnt_n = cnt_q + 16'd1;
                     if (lane_q == 2'd3 || rx_eop) begin
                        pend_n  = 1'b1;
                        pword_n = {sopw_q, rx_eop,
                                   rx_eop ? lane_q : 2'b11, word_ins};
                        sr_n    = '0;
                        lane_n  = '0;
                        sopw_n  = 1'b0;
                        if (rx_eop) state_n = LAST;
                     end else begin
                        sr_n   = word_ins;
                        lane_n = lane_q + 2'd1;
                     end
                  end
               end
            end
         end
         LAST: begin
            if (free == '0) begin
               frame_drop = 1'b1;
               wr_ptr_n   = commit_q;
               state_n    = IDLE;
            end else begin
               wren_a   = 1'b1;
               wr_ptr_n = wr_ptr_q + PW'(1);
               state_n  = HDR;
            end
         end
         HDR: begin
            wren_a     = 1'b1;
            address_a  = hdr_addr_q[ADDR_WIDTH-1:0];
            data_a     = {4'hA, 16'h0000, cnt_q};
            commit_n   = wr_ptr_q;
            frame_done = 1'b1;
            state_n    = IDLE;
         end
         DROP: begin
            if (acc && rx_eop) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (start) begin
         if (rx_eop && rx_err) begin
            frame_drop = 1'b1;
            state_n    = IDLE;
         end else if (fbase < PW'(2)) begin
            frame_drop = 1'b1;
            state_n    = rx_eop ? IDLE : DROP;
         end else begin
            hdr_addr_n = base;
            wr_ptr_n   = base + PW'(1);
            cnt_n      = 16'd1;
            if (rx_eop) begin
               pend_n  = 1'b1;
               pword_n = {4'b1100, 24'h0, rx_data};
               sr_n    = '0;
               lane_n  = '0;
               sopw_n  = 1'b0;
               state_n = LAST;
            end else begin
               sr_n    = {24'h0, rx_data};
               lane_n  = 2'd1;
               sopw_n  = 1'b1;
               state_n = DATA;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         commit_q   <= '0;
         hdr_addr_q <= '0;
         sr_q       <= '0;
         lane_q     <= '0;
         cnt_q      <= '0;
         sopw_q     <= 1'b0;
         pend_q     <= 1'b0;
         pword_q    <= '0;
         ok_q       <= '0;
         drop_q     <= '0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_n;
         wr_ptr_q   <= wr_ptr_n;
         commit_q   <= commit_n;
         hdr_addr_q <= hdr_addr_n;
         sr_q       <= sr_n;
         lane_q     <= lane_n;
         cnt_q      <= cnt_n;
         sopw_q     <= sopw_n;
         pend_q     <= pend_n;
         pword_q    <= pword_n;
         run_q      <= 1'b1;
         if (frame_done && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
         if (frame_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
   end

   assign commit_ptr = commit_q;
   assign ok_cnt     = ok_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_ecat_rx_frame_packer.sv
// Directed bench for ecat_rx_frame_packer with a behavioural frame RAM.
// Expected words and pointers are hand-computed per scenario.
module tb_ecat_rx_frame_packer;

   localparam int AW = 9;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_sop = 1'b0;
   logic          rx_eop = 1'b0;
   logic          rx_err = 1'b0;
   logic          rx_ready;
   logic [AW:0]   rd_ptr = '0;
   logic [35:0]   data_a;
   logic          wren_a;
   logic [AW-1:0] address_a;
   logic [AW:0]   commit_ptr;
   logic          frame_done;
   logic          frame_drop;
   logic [15:0]   ok_cnt;
   logic [15:0]   drop_cnt;

   logic [35:0]   mem [0:(1<<AW)-1];
   int            n_chk = 0;
   int            n_fail = 0;
   int            done_seen = 0;
   int            drop_seen = 0;
   int            hdr_wr = 0;

   ecat_rx_frame_packer #(.ADDR_WIDTH(AW), .MAX_BYTES(1522)) dut (
      .clock(clock), .reset_n(reset_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
      .rx_eop(rx_eop), .rx_err(rx_err), .rx_ready(rx_ready),
      .rd_ptr(rd_ptr), .data_a(data_a), .wren_a(wren_a),
      .address_a(address_a), .commit_ptr(commit_ptr),
      .frame_done(frame_done), .frame_drop(frame_drop),
      .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (reset_n) begin
         if (wren_a) mem[address_a] = data_a;
         if (wren_a && data_a[35:32] == 4'hA) hdr_wr++;
         if (frame_done) done_seen++;
         if (frame_drop) drop_seen++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [7:0] d, input logic s, input logic e,
                       input logic r);
      int n;
      n = 0;
      @(negedge clock);
      while (!rx_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n == 20) chk("ready_wait", rx_ready, 1'b1);
      rx_data  = d;
      rx_sop   = s;
      rx_eop   = e;
      rx_err   = r;
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic send_frame(input int len, input int base, input logic err,
                             input logic with_eop);
      for (int i = 0; i < len; i++)
         beat(8'(base + i), i == 0, with_eop && i == len - 1,
              err && i == len - 1);
   endtask

   task automatic settle();
      repeat (4) @(negedge clock);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rd_ptr   = '0;
      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      done_seen = 0;
      drop_seen = 0;
      hdr_wr    = 0;
      reset_n   = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      repeat (2) @(negedge clock);
      chk("rst_ready", rx_ready, 1'b0);
      chk("rst_wren", wren_a, 1'b0);
      chk("rst_commit", commit_ptr, 0);
      chk("rst_cnts", {ok_cnt, drop_cnt}, 0);
      chk("rst_pulses", {frame_done, frame_drop}, 0);
      chk("rst_bus", {data_a, address_a}, 0);

      // 64-byte good frame
      do_reset();
      send_frame(64, 0, 1'b0, 1'b1);
      settle();
      chk("t1_commit", commit_ptr, 17);
      chk("t1_hdr", mem[0], 36'hA_0000_0040);
      chk("t1_w1", mem[1], 36'hB_0302_0100);
      chk("t1_w2", mem[2], 36'h3_0706_0504);
      chk("t1_w16", mem[16], 36'h7_3F3E_3D3C);
      chk("t1_done", done_seen, 1);
      chk("t1_ok", ok_cnt, 1);
      chk("t1_hdrwr", hdr_wr, 1);

      // 61-byte frame, partial last word
      do_reset();
      send_frame(61, 0, 1'b0, 1'b1);
      settle();
      chk("t2_commit", commit_ptr, 17);
      chk("t2_hdr", mem[0], 36'hA_0000_003D);
      chk("t2_w16", mem[16], 36'h4_0000_003C);

      // Errored frame
      do_reset();
      send_frame(64, 0, 1'b1, 1'b1);
      settle();
      chk("t3_addr", address_a, 0);
      chk("t3_commit", commit_ptr, 0);
      chk("t3_dropcnt", drop_cnt, 1);
      chk("t3_dropseen", drop_seen, 1);
      chk("t3_hdrwr", hdr_wr, 0);
      chk("t3_ok", ok_cnt, 0);

      // Ring fill, overflow drop, then a frame across the wrap
      do_reset();
      for (int f = 0; f < 30; f++) send_frame(64, f, 1'b0, 1'b1);
      settle();
      chk("t4_fill_commit", commit_ptr, 510);
      chk("t4_fill_ok", ok_cnt, 30);
      send_frame(300, 0, 1'b0, 1'b1);
      settle();
      chk("t4_ovf_drop", drop_cnt, 1);
      chk("t4_ovf_commit", commit_ptr, 510);
      rd_ptr = 10'd510;
      send_frame(60, 8'h80, 1'b0, 1'b1);
      settle();
      chk("t4_wrap_commit", commit_ptr, 526);
      chk("t4_wrap_hdr", mem[510], 36'hA_0000_003C);
      chk("t4_wrap_w511", mem[511], 36'hB_8382_8180);
      chk("t4_wrap_w0", mem[0], 36'h3_8786_8584);
      chk("t4_wrap_last", mem[13], 36'h7_BBBA_B9B8);

      // Exactly MAX_BYTES is accepted
      do_reset();
      send_frame(1522, 0, 1'b0, 1'b1);
      settle();
      chk("t5_max_commit", commit_ptr, 382);
      chk("t5_max_hdr", mem[0], 36'hA_0000_05F2);
      chk("t5_max_last", mem[381], 36'h5_0000_F1F0);
      chk("t5_max_ok", ok_cnt, 1);

      // Oversized frame dropped, next one commits
      do_reset();
      send_frame(1600, 0, 1'b0, 1'b1);
      settle();
      chk("t5_big_drop", drop_cnt, 1);
      chk("t5_big_commit", commit_ptr, 0);
      chk("t5_big_ok", ok_cnt, 0);
      send_frame(64, 0, 1'b0, 1'b1);
      settle();
      chk("t5_after_commit", commit_ptr, 17);
      chk("t5_after_ok", ok_cnt, 1);
      chk("t5_after_w1", mem[1], 36'hB_0302_0100);

      // sop mid-frame replaces the open frame
      do_reset();
      send_frame(10, 8'h40, 1'b0, 1'b0);
      send_frame(64, 0, 1'b0, 1'b1);
      settle();
      chk("t6_drop", drop_cnt, 1);
      chk("t6_ok", ok_cnt, 1);
      chk("t6_commit", commit_ptr, 17);
      chk("t6_hdr", mem[0], 36'hA_0000_0040);
      chk("t6_w1", mem[1], 36'hB_0302_0100);

      // Reset in the middle of a frame
      send_frame(20, 0, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_commit", commit_ptr, 0);
      chk("t6_rst_cnts", {ok_cnt, drop_cnt}, 0);
      chk("t6_rst_outs", {rx_ready, wren_a, frame_done, frame_drop}, 0);
      do_reset();
      send_frame(64, 0, 1'b0, 1'b1);
      settle();
      chk("t6_post_commit", commit_ptr, 17);
      chk("t6_post_ok", ok_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
